// File: rtl/ball_motion_ctrl.sv
// Ball position/direction owner for the paddle game: reflects on crash bits,
// steps once per frame tick and sequences IDLE/SERVE/PLAY/MISS rounds.
module ball_motion_ctrl #(
  parameter int X_MIN     = 10,
  parameter int X_MAX     = 630,
  parameter int Y_MIN     = 10,
  parameter int Y_MAX     = 470,
  parameter int START_X   = 320,
  parameter int START_Y   = 240,
  parameter int STEP      = 2,
  parameter int MISS_HOLD = 60,
  parameter int MAX_MISS  = 3
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iFrame_tick,
  input  logic       iStart,
  input  logic [3:0] iCrash,
  output logic [9:0] oBall_x,
  output logic [9:0] oBall_y,
  output logic [1:0] oState,
  output logic [7:0] oBounce_cnt,
  output logic [3:0] oMiss_cnt,
  output logic       oGame_over
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    MISS  = 2'd3
  } state_t;

  localparam int HOLD_W = (MISS_HOLD > 1) ? $clog2(MISS_HOLD + 1) : 1;

  localparam logic [10:0] X_MIN11 = 11'(X_MIN);
  localparam logic [10:0] X_MAX11 = 11'(X_MAX);
  localparam logic [10:0] Y_MIN11 = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX11 = 11'(Y_MAX);
  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [9:0]  START_X10 = 10'(START_X);
  localparam logic [9:0]  START_Y10 = 10'(START_Y);
  localparam logic [3:0]  MAX_MISS4 = 4'(MAX_MISS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MISS_HOLD - 1);

  state_t            state, state_nx;
  logic [9:0]        ball_x, ball_x_nx;
  logic [9:0]        ball_y, ball_y_nx;
  logic              dir_x, dir_x_nx;
  logic              dir_y, dir_y_nx;
  logic [7:0]        bounce_cnt, bounce_cnt_nx;
  logic [3:0]        miss_cnt, miss_cnt_nx;
  logic              game_over, game_over_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;

  function automatic logic [9:0] clamp11(input logic [10:0] v,
                                         input logic [10:0] lo,
                                         input logic [10:0] hi);
    if (v < lo)      return lo[9:0];
    else if (v > hi) return hi[9:0];
    else             return v[9:0];
  endfunction

  // dir=1 means increasing coordinate; a decrement below zero is treated as
  // hitting the low clamp instead of wrapping.
  function automatic logic [9:0] step_axis(input logic [9:0]  p,
                                           input logic        dir,
                                           input logic [10:0] lo,
                                           input logic [10:0] hi);
    logic [10:0] ext;
    ext = {1'b0, p};
    if (dir)                return clamp11(ext + STEP11, lo, hi);
    else if (ext < STEP11)  return lo[9:0];
    else                    return clamp11(ext - STEP11, lo, hi);
  endfunction

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      ball_x     <= START_X10;
      ball_y     <= START_Y10;
      dir_x      <= 1'b1;
      dir_y      <= 1'b0;
      bounce_cnt <= '0;
      miss_cnt   <= '0;
      game_over  <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_nx;
      ball_x     <= ball_x_nx;
      ball_y     <= ball_y_nx;
      dir_x      <= dir_x_nx;
      dir_y      <= dir_y_nx;
      bounce_cnt <= bounce_cnt_nx;
      miss_cnt   <= miss_cnt_nx;
      game_over  <= game_over_nx;
      hold_cnt   <= hold_cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    ball_x_nx     = ball_x;
    ball_y_nx     = ball_y;
    dir_x_nx      = dir_x;
    dir_y_nx      = dir_y;
    bounce_cnt_nx = bounce_cnt;
    miss_cnt_nx   = miss_cnt;
    game_over_nx  = game_over;
    hold_cnt_nx   = hold_cnt;

    unique case (state)
      IDLE: begin
        ball_x_nx = START_X10;
        ball_y_nx = START_Y10;
        dir_x_nx  = 1'b1;
        dir_y_nx  = 1'b0;
        if (iStart) begin
          bounce_cnt_nx = '0;
          miss_cnt_nx   = '0;
          game_over_nx  = 1'b0;
          state_nx      = SERVE;
        end
      end

      SERVE: begin
        ball_x_nx = START_X10;
        ball_y_nx = START_Y10;
        dir_x_nx  = 1'b1;
        dir_y_nx  = 1'b0;
        if (iFrame_tick) state_nx = PLAY;
      end

      PLAY: begin
        if (iFrame_tick) begin
          if ({1'b0, ball_y} >= Y_MAX11) begin
            state_nx    = MISS;
            hold_cnt_nx = '0;
            if (miss_cnt < MAX_MISS4) miss_cnt_nx = miss_cnt + 4'd1;
          end else begin
            if (iCrash[3] && !iCrash[2]) dir_x_nx = 1'b1;
            if (iCrash[2] && !iCrash[3]) dir_x_nx = 1'b0;
            if (iCrash[1] && !iCrash[0]) dir_y_nx = 1'b1;
            if (iCrash[0] && !iCrash[1]) dir_y_nx = 1'b0;
            if (((dir_x_nx != dir_x) || (dir_y_nx != dir_y)) && (bounce_cnt != 8'hFF))
              bounce_cnt_nx = bounce_cnt + 8'd1;
            ball_x_nx = step_axis(ball_x, dir_x_nx, X_MIN11, X_MAX11);
            ball_y_nx = step_axis(ball_y, dir_y_nx, Y_MIN11, Y_MAX11);
          end
        end
      end

      MISS: begin
        if (iFrame_tick) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt_nx = '0;
            ball_x_nx   = START_X10;
            ball_y_nx   = START_Y10;
            dir_x_nx    = 1'b1;
            dir_y_nx    = 1'b0;
            if (miss_cnt == MAX_MISS4) begin
              state_nx     = IDLE;
              game_over_nx = 1'b1;
            end else begin
              state_nx = SERVE;
            end
          end else begin
            hold_cnt_nx = hold_cnt + 1'b1;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  assign oBall_x     = ball_x;
  assign oBall_y     = ball_y;
  assign oState      = state;
  assign oBounce_cnt = bounce_cnt;
  assign oMiss_cnt   = miss_cnt;
  assign oGame_over  = game_over;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench: two ball_motion_ctrl instances (STEP 2 and 4) driven in
// lockstep against a behavioural model, plus directed scenario checks.
module tb_ball_motion_ctrl;

  localparam int P_HOLD = 4;
  localparam int P_MAX  = 3;

  typedef struct {
    int x; int y; int st; int bc; int mc; int go;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, tick, start;
  logic [3:0] crash [2];
  logic [9:0] bx [2];
  logic [9:0] by [2];
  logic [1:0] st [2];
  logic [7:0] bc [2];
  logic [3:0] mc [2];
  logic       go [2];

  int m_st[2], m_x[2], m_y[2], m_dx[2], m_dy[2], m_bc[2], m_mc[2], m_go[2], m_hold[2];
  int steps[2] = '{2, 4};
  exp_t sb0[$];
  exp_t sb1[$];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ball_motion_ctrl #(.STEP(2), .MISS_HOLD(P_HOLD), .MAX_MISS(P_MAX)) dut0 (
    .iCLK(clk), .iRST_N(rst_n), .iFrame_tick(tick), .iStart(start), .iCrash(crash[0]),
    .oBall_x(bx[0]), .oBall_y(by[0]), .oState(st[0]), .oBounce_cnt(bc[0]),
    .oMiss_cnt(mc[0]), .oGame_over(go[0]));

  ball_motion_ctrl #(.STEP(4), .MISS_HOLD(P_HOLD), .MAX_MISS(P_MAX)) dut1 (
    .iCLK(clk), .iRST_N(rst_n), .iFrame_tick(tick), .iStart(start), .iCrash(crash[1]),
    .oBall_x(bx[1]), .oBall_y(by[1]), .oState(st[1]), .oBounce_cnt(bc[1]),
    .oMiss_cnt(mc[1]), .oGame_over(go[1]));

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic setServe(input int i);
    m_x[i] = 320; m_y[i] = 240; m_dx[i] = 1; m_dy[i] = -1;
  endtask

  task automatic modelReset(input int i);
    m_st[i] = 0; setServe(i);
    m_bc[i] = 0; m_mc[i] = 0; m_go[i] = 0; m_hold[i] = 0;
  endtask

  task automatic modelStep(input int i);
    int ndx, ndy;
    logic [3:0] c;
    c = crash[i];
    case (m_st[i])
      0: if (start) begin
        m_bc[i] = 0; m_mc[i] = 0; m_go[i] = 0; m_st[i] = 1; setServe(i);
      end
      1: if (tick) m_st[i] = 2;
      2: if (tick) begin
        if (m_y[i] >= 470) begin
          m_st[i] = 3; m_hold[i] = 0;
          if (m_mc[i] < P_MAX) m_mc[i]++;
        end else begin
          ndx = m_dx[i]; ndy = m_dy[i];
          if (c[3] && !c[2]) ndx = 1;
          if (c[2] && !c[3]) ndx = -1;
          if (c[1] && !c[0]) ndy = 1;
          if (c[0] && !c[1]) ndy = -1;
          if ((ndx != m_dx[i] || ndy != m_dy[i]) && m_bc[i] < 255) m_bc[i]++;
          m_dx[i] = ndx; m_dy[i] = ndy;
          m_x[i] = clampi(m_x[i] + ndx * steps[i], 10, 630);
          m_y[i] = clampi(m_y[i] + ndy * steps[i], 10, 470);
        end
      end
      default: if (tick) begin
        m_hold[i]++;
        if (m_hold[i] == P_HOLD) begin
          setServe(i);
          if (m_mc[i] == P_MAX) begin m_st[i] = 0; m_go[i] = 1; end
          else m_st[i] = 1;
        end
      end
    endcase
  endtask

  function automatic logic [3:0] genCrash(input int i);
    logic [3:0] c;
    c = 4'b0000;
    if (m_x[i] <= 10)  c[3] = 1'b1;
    if (m_x[i] >= 630) c[2] = 1'b1;
    if (m_y[i] <= 10)  c[1] = 1'b1;
    if (m_y[i] >= 440 && $urandom_range(0, 19) == 0) c[0] = 1'b1;
    if ($urandom_range(0, 15) == 0) c[$urandom_range(0, 3)] = 1'b1;
    return c;
  endfunction

  task automatic checkInst(input int i, input exp_t e);
    checkOutput($sformatf("sb%0d_x", i),  int'(bx[i]), e.x);
    checkOutput($sformatf("sb%0d_y", i),  int'(by[i]), e.y);
    checkOutput($sformatf("sb%0d_st", i), int'(st[i]), e.st);
    checkOutput($sformatf("sb%0d_bc", i), int'(bc[i]), e.bc);
    checkOutput($sformatf("sb%0d_mc", i), int'(mc[i]), e.mc);
    checkOutput($sformatf("sb%0d_go", i), int'(go[i]), e.go);
  endtask

  // One clock: drive at negedge, predict, then compare just after the posedge.
  task automatic applyStimulus(input logic tk, input logic stt,
                               input logic use_force, input logic [3:0] cr);
    exp_t e;
    @(negedge clk);
    tick = tk; start = stt;
    for (int i = 0; i < 2; i++) begin
      crash[i] = use_force ? cr : genCrash(i);
      modelStep(i);
      e = '{m_x[i], m_y[i], m_st[i], m_bc[i], m_mc[i], m_go[i]};
      if (i == 0) sb0.push_back(e); else sb1.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb0.size() == 0 || sb1.size() == 0)
      checkOutput("sb_underflow", 1, 0);
    else begin
      checkInst(0, sb0.pop_front());
      checkInst(1, sb1.pop_front());
    end
  endtask

  task automatic checkResetValues(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s%0d_x", tag, i),  int'(bx[i]), 320);
      checkOutput($sformatf("%s%0d_y", tag, i),  int'(by[i]), 240);
      checkOutput($sformatf("%s%0d_st", tag, i), int'(st[i]), 0);
      checkOutput($sformatf("%s%0d_bc", tag, i), int'(bc[i]), 0);
      checkOutput($sformatf("%s%0d_mc", tag, i), int'(mc[i]), 0);
      checkOutput($sformatf("%s%0d_go", tag, i), int'(go[i]), 0);
    end
  endtask

  initial begin
    int n, fx, fy;
    rst_n = 1'b1; tick = 1'b0; start = 1'b0;
    crash[0] = 4'b0; crash[1] = 4'b0;
    modelReset(0); modelReset(1);
    #1 rst_n = 1'b0;
    #1 checkResetValues("rst");
    @(negedge clk) rst_n = 1'b1;

    // Serve sequence and first move
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000);
    checkOutput("serve_st", int'(st[0]), 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
    checkOutput("play_st", int'(st[0]), 2);
    checkOutput("play_x_nomove", int'(bx[0]), 320);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
    checkOutput("move_x", int'(bx[0]), 322);
    checkOutput("move_y", int'(by[0]), 238);

    // Top clamp on the STEP=4 instance: 12 -> 10, then up-crash -> 14
    n = 0;
    while (m_y[1] != 12 && n < 200) begin applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000); n++; end
    checkOutput("reach_y12", m_y[1], 12);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
    checkOutput("clamp_y10", int'(by[1]), 10);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0010);
    checkOutput("bounce_y14", int'(by[1]), 14);
    checkOutput("bounce_cnt1", int'(bc[1]), 1);
    checkOutput("bounce_cnt0", int'(bc[0]), 1);

    // Right-wall reflection on the STEP=2 instance
    n = 0;
    while (m_x[0] < 630 && n < 300) begin applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000); n++; end
    checkOutput("reach_x630", int'(bx[0]), 630);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0100);
    checkOutput("refl_x", int'(bx[0]), 628);
    checkOutput("refl_bc", int'(bc[0]), 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0100);
    checkOutput("refl2_x", int'(bx[0]), 626);
    checkOutput("refl2_bc", int'(bc[0]), 2);

    // Miss at the bottom edge, hold, re-serve
    n = 0;
    while (m_y[0] < 470 && n < 400) begin applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000); n++; end
    checkOutput("reach_y470", int'(by[0]), 470);
    fx = m_x[0]; fy = m_y[0];
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0001);
    checkOutput("miss_st", int'(st[0]), 3);
    checkOutput("miss_mc", int'(mc[0]), 1);
    checkOutput("miss_frz_x", int'(bx[0]), fx);
    checkOutput("miss_frz_y", int'(by[0]), fy);
    for (int k = 0; k < P_HOLD - 1; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
      checkOutput("hold_st", int'(st[0]), 3);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
    checkOutput("reserve_st", int'(st[0]), 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
    checkOutput("replay_st", int'(st[0]), 2);
    checkOutput("replay_x", int'(bx[0]), 320);
    checkOutput("replay_y", int'(by[0]), 240);

    // Random play until the STEP=2 instance reaches game over
    n = 0;
    while (!(m_st[0] == 0 && m_go[0] == 1) && n < 30000) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, 1'b0, 4'b0000);
      n++;
    end
    checkOutput("gover_st", int'(st[0]), 0);
    checkOutput("gover_go", int'(go[0]), 1);
    checkOutput("gover_mc", int'(mc[0]), P_MAX);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'b0000);
    checkOutput("restart_st", int'(st[0]), 1);
    checkOutput("restart_go", int'(go[0]), 0);
    checkOutput("restart_mc", int'(mc[0]), 0);
    checkOutput("restart_bc", int'(bc[0]), 0);
    for (int k = 0; k < 40; k++)
      applyStimulus($urandom_range(0, 1) == 1, 1'b0, 1'b0, 4'b0000);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1 checkResetValues("arst");
    modelReset(0); modelReset(1);
    @(negedge clk);
    tick = 1'b0; start = 1'b0; rst_n = 1'b1;

    // Bounce counter saturation
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
    for (int k = 0; k < 300; k++)
      applyStimulus(1'b1, 1'b0, 1'b1, (k % 2 == 0) ? 4'b0100 : 4'b1000);
    checkOutput("sat_bc0", int'(bc[0]), 255);
    checkOutput("sat_bc1", int'(bc[1]), 255);
    checkOutput("sat_st0", int'(st[0]), 2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
